image_addr_gen: RTL and testbench
=================================

Name: image_addr_gen

Overview:
- Parametrised SDRAM/SRAM address generator for the image pipeline.
- SDRAM side: burst-stepped linear read pointer from a start address to a finish address, with a done flag.
- SRAM side: CACHE_ROWS-line ring-buffer row cache (column/row counters with wrap) plus a linear output-region pointer.
- Sits between the controller FSM and the SDRAM/SRAM interface blocks.

Parameters:
- ADDR_W, 26, width of every address bus.
- WIDTH_W, 13, width of image_width.
- CACHE_ROWS, 3, number of image lines held in the SRAM row-cache ring; must be ≥ 2.
- BURST, 1, SDRAM address step per sdram_update; must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- n_rst  in  1  synchronous active-low reset.
- start  in  1  latch bases/width/bounds, clear counters, enter RUN.
- sdram_update  in  1  consume current SDRAM address.
- sram_update  in  1  consume current SRAM address.
- sram_mode  in  1  0 = row-cache region, 1 = output region.
- image_width  in  WIDTH_W  pixels per line; sampled on start.
- sdram_start  in  ADDR_W  first SDRAM address; sampled on start.
- sdram_finish  in  ADDR_W  last SDRAM address, inclusive; sampled on start.
- cache_base  in  ADDR_W  SRAM row-cache base; sampled on start.
- out_base  in  ADDR_W  SRAM output base; sampled on start.
- sdram_addr  out  ADDR_W  current SDRAM address.
- sram_addr  out  ADDR_W  current SRAM address for the selected region.
- cache_row  out  $clog2(CACHE_ROWS)  current ring line index.
- sdram_done  out  1  SDRAM range exhausted (level).
- row_done  out  1  one-cycle pulse: a cache line has been completely written.

Behaviour:
- Reset (n_rst = 0 at an edge): state IDLE; all registers and outputs 0.
- Latency: every counter is registered. An update sampled at edge k shows its new address after edge k, so it is valid in cycle k+1.
- SDRAM FSM states: IDLE, RUN, DONE.
  - IDLE: updates are ignored. start -> RUN.
  - start in any state: sdram_addr <= sdram_start, then RUN. If sdram_finish < sdram_start, go to DONE instead.
  - RUN, on sdram_update: compute sum = sdram_addr + BURST at ADDR_W+1 bits. If sum > finish, go to DONE and hold sdram_addr. Otherwise sdram_addr <= sum.
  - DONE: sdram_updates are ignored. Only start or reset leave DONE.
  - sdram_done = (state == DONE).
- Row cache (sram_mode = 0):
  - Registers: col (WIDTH_W bits), row (cache_row), row_base (ADDR_W bits).
  - sram_addr = row_base + col, truncated to ADDR_W.
  - On sram_update with col == width_eff - 1: col <= 0 and row_done pulses in the next cycle.
    - If row == CACHE_ROWS - 1: row <= 0, row_base <= cache_base.
    - Otherwise: row++, row_base += width_eff.
  - On any other sram_update: col++.
  - width_eff = max(latched image_width, 1). A width of 0 behaves as width 1.
- Output region (sram_mode = 1):
  - sram_addr = out_ptr.
  - sram_update increments out_ptr, wrapping modulo 2^ADDR_W.
  - The row-cache counters hold.
- sram_update is ignored in IDLE and honoured in RUN and DONE. The SRAM side is independent of SDRAM exhaustion.
- Mode switching: changing sram_mode never disturbs either region's counters. sram_addr follows sram_mode combinationally.
- Start clears everything: col, row, row_done; row_base <= cache_base; out_ptr <= out_base.
- Simultaneous events:
  - start with any update in the same cycle: start wins and the update is dropped.
  - sdram_update and sram_update in the same cycle: both are honoured.
- Reset mid-operation: all state returns to IDLE and zero values, and pending pulses are cancelled.

Decomposition:
- Shared package image_addr_pkg holds:
  - the SDRAM FSM state enum (IDLE, RUN, DONE);
  - the mode localparams MODE_CACHE = 0 and MODE_OUT = 1;
  - the default parameter constants.
- One sub-module, ring_line_counter, holds the col/row/row_base ring logic with the width_eff clamp. The SDRAM FSM and the output pointer stay in the top level.

Test Plan:
- Reset: hold n_rst = 0 for 2 cycles, then toggle updates with no start -> all outputs stay 0, sdram_done = 0.
- SDRAM burst: BURST = 4, start = 100, finish = 111; start, then 4 updates -> sdram_addr sequence 100, 104, 108, then holds at 108; sdram_done goes high after the 3rd update; the 4th update is ignored.
- Row-cache wrap: CACHE_ROWS = 3, width = 4, cache_base = 1000; 13 sram_updates in mode 0 -> sram_addr runs 1000..1011, then returns to 1000; row_done pulses after updates 4, 8 and 12; cache_row sequence 0, 1, 2, 0.
- Mode interleave: cache_base = 0, out_base = 500, width = 4; 2 updates in mode 0, 3 in mode 1, then 1 in mode 0 -> sram_addr sequence 0, 1, 500, 501, 502, 2 (sram_addr reads 503 after the last mode-1 update).
- Edge cases:
  - finish < start -> sdram_done = 1 one cycle after start.
  - width = 0 -> row_done pulses on every sram_update.
  - start and sdram_update in the same cycle -> sdram_addr = sdram_start.
- Restart and reset mid-run: pulse start during RUN with new bases -> all counters reload; assert n_rst = 0 mid-row -> outputs are 0 on the next cycle and no row_done pulse follows.

Source files
------------

// File: rtl/image_addr_gen_pkg.sv
// Shared types and defaults for the image pipeline address generator.
package image_addr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sdram_state_e;

    localparam logic MODE_CACHE = 1'b0;
    localparam logic MODE_OUT   = 1'b1;

    localparam int unsigned DEF_ADDR_W     = 26;
    localparam int unsigned DEF_WIDTH_W    = 13;
    localparam int unsigned DEF_CACHE_ROWS = 3;
    localparam int unsigned DEF_BURST      = 1;

endpackage

// File: rtl/image_addr_gen_ring_line_counter.sv
// Column/row/row-base counters for the SRAM row-cache ring, with the
// zero-width clamp applied to the latched line width.
module ring_line_counter
    import image_addr_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned WIDTH_W    = DEF_WIDTH_W,
    parameter int unsigned CACHE_ROWS = DEF_CACHE_ROWS
) (
    input  logic                          clk_i,
    input  logic                          n_rst_i,
    input  logic                          load_i,
    input  logic                          step_i,
    input  logic [ADDR_W-1:0]             base_i,
    input  logic [WIDTH_W-1:0]            width_i,
    output logic [WIDTH_W-1:0]            col_o,
    output logic [$clog2(CACHE_ROWS)-1:0] row_o,
    output logic [ADDR_W-1:0]             row_base_o,
    output logic                          row_done_o
);

    localparam int unsigned ROW_W = $clog2(CACHE_ROWS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(CACHE_ROWS - 1);

    logic [WIDTH_W-1:0] width_q;
    logic [WIDTH_W-1:0] width_eff;
    logic [ADDR_W-1:0]  base_q;
    logic [WIDTH_W-1:0] col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic               row_done_q, row_done_d;
    logic               line_end;

    always_comb begin
        width_eff  = (width_q == '0) ? WIDTH_W'(1) : width_q;
        line_end   = (col_q == (width_eff - WIDTH_W'(1)));
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        row_done_d = 1'b0;
        if (step_i) begin
            if (line_end) begin
                col_d      = '0;
                row_done_d = 1'b1;
                if (row_q == ROW_LAST) begin
                    row_d      = '0;
                    row_base_d = base_q;
                end else begin
                    row_d      = row_q + ROW_W'(1);
                    row_base_d = row_base_q + ADDR_W'(width_eff);
                end
            end else begin
                col_d = col_q + WIDTH_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            width_q    <= '0;
            base_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            row_done_q <= 1'b0;
        end else if (load_i) begin
            width_q    <= width_i;
            base_q     <= base_i;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= base_i;
            row_done_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            row_done_q <= row_done_d;
        end
    end

    assign col_o      = col_q;
    assign row_o      = row_q;
    assign row_base_o = row_base_q;
    assign row_done_o = row_done_q;

endmodule

// File: rtl/image_addr_gen.sv
// SDRAM burst read pointer plus SRAM row-cache ring / output-region pointer
// for the image pipeline.
module image_addr_gen
    import image_addr_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned WIDTH_W    = DEF_WIDTH_W,
    parameter int unsigned CACHE_ROWS = DEF_CACHE_ROWS,
    parameter int unsigned BURST      = DEF_BURST
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          start,
    input  logic                          sdram_update,
    input  logic                          sram_update,
    input  logic                          sram_mode,
    input  logic [WIDTH_W-1:0]            image_width,
    input  logic [ADDR_W-1:0]             sdram_start,
    input  logic [ADDR_W-1:0]             sdram_finish,
    input  logic [ADDR_W-1:0]             cache_base,
    input  logic [ADDR_W-1:0]             out_base,
    output logic [ADDR_W-1:0]             sdram_addr,
    output logic [ADDR_W-1:0]             sram_addr,
    output logic [$clog2(CACHE_ROWS)-1:0] cache_row,
    output logic                          sdram_done,
    output logic                          row_done
);

    localparam logic [ADDR_W:0] BURST_EXT = (ADDR_W+1)'(BURST);

    sdram_state_e      state_q;
    logic [ADDR_W-1:0] sdram_addr_q;
    logic [ADDR_W-1:0] finish_q;
    logic              sdram_done_q;
    logic [ADDR_W-1:0] out_ptr_q;
    logic [ADDR_W:0]   sum;
    logic              active;
    logic              sram_go;
    logic              cache_step;

    logic [WIDTH_W-1:0] col;
    logic [ADDR_W-1:0]  row_base;

    // Sum is one bit wider so a burst stepping past the top of the address
    // space still compares greater than the finish address.
    assign sum        = {1'b0, sdram_addr_q} + BURST_EXT;
    assign active     = (state_q != IDLE);
    assign sram_go    = active && sram_update && !start;
    assign cache_step = sram_go && (sram_mode == MODE_CACHE);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            sdram_addr_q <= '0;
            finish_q     <= '0;
            sdram_done_q <= 1'b0;
        end else if (start) begin
            sdram_addr_q <= sdram_start;
            finish_q     <= sdram_finish;
            if (sdram_finish < sdram_start) begin
                state_q      <= DONE;
                sdram_done_q <= 1'b1;
            end else begin
                state_q      <= RUN;
                sdram_done_q <= 1'b0;
            end
        end else if (state_q == RUN && sdram_update) begin
            if (sum > {1'b0, finish_q}) begin
                state_q      <= DONE;
                sdram_done_q <= 1'b1;
            end else begin
                sdram_addr_q <= sum[ADDR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            out_ptr_q <= '0;
        end else if (start) begin
            out_ptr_q <= out_base;
        end else if (sram_go && sram_mode == MODE_OUT) begin
            out_ptr_q <= out_ptr_q + ADDR_W'(1);
        end
    end

    ring_line_counter #(
        .ADDR_W     (ADDR_W),
        .WIDTH_W    (WIDTH_W),
        .CACHE_ROWS (CACHE_ROWS)
    ) u_ring (
        .clk_i      (clk),
        .n_rst_i    (n_rst),
        .load_i     (start),
        .step_i     (cache_step),
        .base_i     (cache_base),
        .width_i    (image_width),
        .col_o      (col),
        .row_o      (cache_row),
        .row_base_o (row_base),
        .row_done_o (row_done)
    );

    assign sdram_addr = sdram_addr_q;
    assign sdram_done = sdram_done_q;
    assign sram_addr  = (sram_mode == MODE_OUT) ? out_ptr_q
                                                : (row_base + ADDR_W'(col));

endmodule

// File: tb/tb_image_addr_gen.sv
// Randomised and directed bench for image_addr_gen against an arithmetic
// reference model (pointer = base + count, reduced modulo the ring size).
module tb_image_addr_gen;

    localparam int unsigned ADDR_W     = 26;
    localparam int unsigned WIDTH_W    = 13;
    localparam int unsigned CACHE_ROWS = 3;
    localparam int unsigned BURST      = 4;
    localparam int unsigned ROW_W      = $clog2(CACHE_ROWS);
    localparam longint unsigned MASK   = (64'd1 << ADDR_W) - 1;

    logic                clk = 1'b0;
    logic                n_rst = 1'b0;
    logic                start = 1'b0;
    logic                sdram_update = 1'b0;
    logic                sram_update = 1'b0;
    logic                sram_mode = 1'b0;
    logic [WIDTH_W-1:0]  image_width = '0;
    logic [ADDR_W-1:0]   sdram_start = '0;
    logic [ADDR_W-1:0]   sdram_finish = '0;
    logic [ADDR_W-1:0]   cache_base = '0;
    logic [ADDR_W-1:0]   out_base = '0;
    logic [ADDR_W-1:0]   sdram_addr;
    logic [ADDR_W-1:0]   sram_addr;
    logic [ROW_W-1:0]    cache_row;
    logic                sdram_done;
    logic                row_done;

    image_addr_gen #(
        .ADDR_W     (ADDR_W),
        .WIDTH_W    (WIDTH_W),
        .CACHE_ROWS (CACHE_ROWS),
        .BURST      (BURST)
    ) u_dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .sdram_update (sdram_update),
        .sram_update  (sram_update),
        .sram_mode    (sram_mode),
        .image_width  (image_width),
        .sdram_start  (sdram_start),
        .sdram_finish (sdram_finish),
        .cache_base   (cache_base),
        .out_base     (out_base),
        .sdram_addr   (sdram_addr),
        .sram_addr    (sram_addr),
        .cache_row    (cache_row),
        .sdram_done   (sdram_done),
        .row_done     (row_done)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state: SDRAM as start + steps*BURST, SRAM cache as a
    // linear count reduced modulo CACHE_ROWS*width, output as base + count.
    bit              m_active = 1'b0;
    bit              m_done   = 1'b0;
    bit              m_rd     = 1'b0;
    longint unsigned m_sd_start = 0, m_finish = 0, m_steps = 0, m_max = 0;
    longint unsigned m_base = 0, m_weff = 1, m_n = 0, m_obase = 0, m_k = 0;

    task automatic check_val(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!n_rst) begin
            m_active = 1'b0; m_done = 1'b0; m_rd = 1'b0;
            m_sd_start = 0; m_finish = 0; m_steps = 0; m_max = 0;
            m_base = 0; m_weff = 1; m_n = 0; m_obase = 0; m_k = 0;
        end else if (start) begin
            m_active   = 1'b1;
            m_sd_start = sdram_start;
            m_finish   = sdram_finish;
            m_steps    = 0;
            m_done     = (sdram_finish < sdram_start);
            m_max      = m_done ? 0 : (m_finish - m_sd_start) / BURST;
            m_base     = cache_base;
            m_weff     = (image_width == 0) ? 1 : image_width;
            m_n        = 0;
            m_obase    = out_base;
            m_k        = 0;
            m_rd       = 1'b0;
        end else begin
            m_rd = 1'b0;
            if (m_active) begin
                if (sdram_update && !m_done) begin
                    if (m_steps == m_max) m_done = 1'b1;
                    else m_steps++;
                end
                if (sram_update) begin
                    if (sram_mode == 1'b0) begin
                        m_n  = (m_n + 1) % (CACHE_ROWS * m_weff);
                        m_rd = ((m_n % m_weff) == 0);
                    end else begin
                        m_k++;
                    end
                end
            end
        end
    endtask

    task automatic cycle(input bit st, input bit sdu, input bit sru, input bit md);
        start        = st;
        sdram_update = sdu;
        sram_update  = sru;
        sram_mode    = md;
        @(posedge clk);
        model_edge();
        #1;
        check_val("sdram_addr", sdram_addr, (m_sd_start + m_steps * BURST) & MASK);
        check_val("sdram_done", sdram_done, m_done);
        check_val("cache_row", cache_row, m_n / m_weff);
        check_val("row_done", row_done, m_rd);
        check_val("sram_addr", sram_addr,
                  md ? ((m_obase + m_k) & MASK) : ((m_base + m_n) & MASK));
    endtask

    task automatic set_params(input longint unsigned ss, input longint unsigned sf,
                              input longint unsigned cb, input longint unsigned ob,
                              input int unsigned w);
        sdram_start  = ADDR_W'(ss);
        sdram_finish = ADDR_W'(sf);
        cache_base   = ADDR_W'(cb);
        out_base     = ADDR_W'(ob);
        image_width  = WIDTH_W'(w);
    endtask

    task automatic rand_params();
        longint unsigned ss, sf, cb, ob;
        ss = ($urandom_range(0, 7) == 0) ? MASK - $urandom_range(0, 20) : $urandom_range(0, 5000);
        sf = ($urandom_range(0, 3) == 0) ? ss - $urandom_range(1, 5) : ss + $urandom_range(0, 40);
        cb = ($urandom_range(0, 7) == 0) ? MASK - $urandom_range(0, 10) : $urandom_range(0, 100000);
        ob = ($urandom_range(0, 7) == 0) ? MASK - $urandom_range(0, 10) : $urandom_range(0, 100000);
        set_params(ss, sf, cb, ob, $urandom_range(0, 6));
    endtask

    initial begin
        // Reset held two cycles, then activity without start must do nothing.
        n_rst = 1'b0;
        cycle(0, 1, 1, 0);
        cycle(0, 0, 1, 1);
        n_rst = 1'b1;
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, i[0]);
        check_val("idle_sdram_addr", sdram_addr, 0);
        check_val("idle_sdram_done", sdram_done, 0);

        // SDRAM burst stepping and exhaustion.
        set_params(100, 111, 1000, 500, 4);
        cycle(1, 0, 0, 0);
        check_val("burst_first", sdram_addr, 100);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
        check_val("burst_hold", sdram_addr, 108);
        check_val("burst_done", sdram_done, 1);

        // Row-cache ring wrap over three lines of width 4.
        cycle(1, 0, 0, 0);
        for (int i = 1; i <= 13; i++) cycle(0, 0, 1, 0);
        check_val("ring_wrap_addr", sram_addr, 1001);

        // Mode interleave keeps each region's counters intact.
        set_params(100, 111, 0, 500, 4);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1);
        check_val("out_ptr_503", sram_addr, 503);
        cycle(0, 0, 1, 0);
        check_val("cache_resume", sram_addr, 3);

        // finish < start finishes immediately.
        set_params(50, 40, 0, 0, 4);
        cycle(1, 0, 0, 0);
        check_val("empty_range_done", sdram_done, 1);
        cycle(0, 1, 0, 0);

        // Zero width behaves as width one.
        set_params(0, 100, 20, 0, 0);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 0);
            check_val("w0_row_done", row_done, 1);
        end

        // start beats a same-cycle update.
        set_params(200, 300, 0, 0, 4);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 1, 1, 0);
        check_val("start_wins", sdram_addr, 200);

        // Restart mid-run, then reset mid-row.
        cycle(0, 1, 1, 0);
        set_params(7000, 7100, 3000, 9000, 5);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 1);
        cycle(0, 0, 1, 0);
        n_rst = 1'b0;
        cycle(0, 1, 1, 0);
        check_val("mid_reset_addr", sram_addr, 0);
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0);

        // Randomised traffic.
        for (int i = 0; i < 4000; i++) begin
            rand_params();
            n_rst = ($urandom_range(0, 199) != 0);
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
